// File: rtl/prbs_rate_sweep_if.sv
// Bundle of the sweep controller's control, configuration and generator-side
// signals.
//   master : drives start/stop/loop_mode, the table write port and sym_tick;
//            observes the generator controls and the status flags.
//   slave  : the controller side, with the directions reversed.
interface prbs_rate_sweep_if #(
   parameter int RATE_NUM = 4,
   parameter int DIV_W    = 32,
   parameter int SYMS_W   = 16
);
   localparam int IDX_W = $clog2(RATE_NUM);

   logic              start;
   logic              stop;
   logic              loop_mode;
   logic              cfg_we;
   logic [IDX_W-1:0]  cfg_addr;
   logic [DIV_W-1:0]  cfg_div;
   logic [SYMS_W-1:0] cfg_syms;
   logic              sym_tick;
   logic [DIV_W-1:0]  div_value;
   logic              gen_en;
   logic              seed_load;
   logic [IDX_W-1:0]  rate_idx;
   logic              busy;
   logic              done;
   logic              cfg_err;

   modport master (
      output start, stop, loop_mode, cfg_we, cfg_addr, cfg_div, cfg_syms, sym_tick,
      input  div_value, gen_en, seed_load, rate_idx, busy, done, cfg_err
   );

   modport slave (
      input  start, stop, loop_mode, cfg_we, cfg_addr, cfg_div, cfg_syms, sym_tick,
      output div_value, gen_en, seed_load, rate_idx, busy, done, cfg_err
   );
endinterface

// File: rtl/prbs_rate_sweep_ctrl.sv
// Sweep sequencer for the PRBS/Manchester generator. It holds a table of
// (divider, symbol count) entries. For each entry with a non-zero symbol
// count it loads the divider, pulses the LFSR seed reload, and enables the
// generator for the programmed number of symbols. It then moves on to the
// next entry. Sweeps run once or repeat, and stop aborts them.
//
// Ports: clk, rst_n (async, active low); bus (slave modport) carries
//   start/stop/loop_mode, the cfg_* table write port, sym_tick from the
//   generator, and the registered outputs div_value, gen_en, seed_load,
//   rate_idx, busy, done and cfg_err.
//
// state | meaning
// IDLE  | waiting for start; table writes accepted
// SCAN  | checking one table entry per cycle for a non-zero symbol count
// LOAD  | one cycle: present divider/index, pulse seed_load
// RUN   | generator enabled, counting sym_tick up to the entry's count
// DONE  | one cycle: done pulse, then back to IDLE
module prbs_rate_sweep_ctrl #(
   parameter int RATE_NUM = 4,
   parameter int DIV_W    = 32,
   parameter int SYMS_W   = 16,
   parameter int DIV_MIN  = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   prbs_rate_sweep_if.slave    bus
);
   localparam int IDX_W = $clog2(RATE_NUM);

   typedef enum logic [2:0] {IDLE, SCAN, LOAD, RUN, DONE} state_t;

   state_t            state;
   logic [DIV_W-1:0]  div_tbl  [RATE_NUM];
   logic [SYMS_W-1:0] syms_tbl [RATE_NUM];
   logic [IDX_W-1:0]  idx;
   logic [IDX_W:0]    scan_cnt;
   logic [SYMS_W-1:0] sym_cnt;
   logic              ran;
   logic              loop_lat;
   logic              wrap_end;

   logic [DIV_W-1:0]  div_value_q;
   logic              gen_en_q;
   logic              seed_load_q;
   logic [IDX_W-1:0]  rate_idx_q;
   logic              busy_q;
   logic              done_q;
   logic              cfg_err_q;

   logic cur_valid;
   logic at_last;
   logic stop_hit;

   assign cur_valid = (syms_tbl[idx] != '0);
   assign at_last   = (idx == IDX_W'(RATE_NUM - 1));
   assign stop_hit  = bus.stop && ((state == SCAN) || (state == LOAD) || (state == RUN));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         idx         <= '0;
         scan_cnt    <= '0;
         sym_cnt     <= '0;
         ran         <= 1'b0;
         loop_lat    <= 1'b0;
         wrap_end    <= 1'b0;
         div_value_q <= '0;
         gen_en_q    <= 1'b0;
         seed_load_q <= 1'b0;
         rate_idx_q  <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         cfg_err_q   <= 1'b0;
         for (int i = 0; i < RATE_NUM; i++) begin
            div_tbl[i]  <= DIV_W'(DIV_MIN);
            syms_tbl[i] <= '0;
         end
      end else begin
         seed_load_q <= 1'b0;
         done_q      <= 1'b0;
         cfg_err_q   <= 1'b0;

         if (bus.cfg_we) begin
            if ((state == IDLE) && (bus.cfg_div >= DIV_W'(DIV_MIN))) begin
               div_tbl[bus.cfg_addr]  <= bus.cfg_div;
               syms_tbl[bus.cfg_addr] <= bus.cfg_syms;
            end else begin
               cfg_err_q <= 1'b1;
            end
         end

         // stop outranks everything, including an end-of-entry tick this cycle
         if (stop_hit) begin
            state    <= DONE;
            gen_en_q <= 1'b0;
            done_q   <= 1'b1;
         end else begin
            case (state)
               IDLE: begin
                  if (bus.start && !bus.stop) begin
                     state    <= SCAN;
                     idx      <= '0;
                     scan_cnt <= '0;
                     ran      <= 1'b0;
                     wrap_end <= 1'b0;
                     loop_lat <= bus.loop_mode;
                     busy_q   <= 1'b1;
                  end
               end
               SCAN: begin
                  // wrap_end: the entry just finished was the last one of a single pass
                  if (wrap_end) begin
                     state  <= DONE;
                     done_q <= 1'b1;
                  end else if (cur_valid) begin
                     state <= LOAD;
                  end else if ((scan_cnt == (IDX_W+1)'(RATE_NUM - 1)) ||
                               (at_last && (!loop_lat || !ran))) begin
                     state  <= DONE;
                     done_q <= 1'b1;
                  end else begin
                     idx      <= idx + 1'b1;
                     scan_cnt <= scan_cnt + 1'b1;
                  end
               end
               LOAD: begin
                  div_value_q <= div_tbl[idx];
                  rate_idx_q  <= idx;
                  seed_load_q <= 1'b1;
                  sym_cnt     <= '0;
                  ran         <= 1'b1;
                  gen_en_q    <= 1'b1;
                  state       <= RUN;
               end
               RUN: begin
                  if (bus.sym_tick) begin
                     if (sym_cnt == (syms_tbl[idx] - SYMS_W'(1))) begin
                        gen_en_q <= 1'b0;
                        state    <= SCAN;
                        idx      <= idx + 1'b1;
                        scan_cnt <= '0;
                        wrap_end <= at_last && !loop_lat;
                     end else begin
                        sym_cnt <= sym_cnt + 1'b1;
                     end
                  end
               end
               DONE: begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end
               default: begin
                  state    <= IDLE;
                  busy_q   <= 1'b0;
                  gen_en_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.div_value = div_value_q;
   assign bus.gen_en    = gen_en_q;
   assign bus.seed_load = seed_load_q;
   assign bus.rate_idx  = rate_idx_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.cfg_err   = cfg_err_q;
endmodule

// File: tb/tb_prbs_rate_sweep_ctrl.sv
module tb_prbs_rate_sweep_ctrl;
   localparam int RATE_NUM = 4;
   localparam int DIV_W    = 32;
   localparam int SYMS_W   = 16;
   localparam int DIV_MIN  = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   prbs_rate_sweep_if #(.RATE_NUM(RATE_NUM), .DIV_W(DIV_W), .SYMS_W(SYMS_W)) bus ();

   prbs_rate_sweep_ctrl #(.RATE_NUM(RATE_NUM), .DIV_W(DIV_W), .SYMS_W(SYMS_W), .DIV_MIN(DIV_MIN)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      bit          is_done;
      int unsigned div;
      int          idx;
      int          syms;
   } exp_t;

   exp_t        exp_q[$];
   int unsigned m_div  [RATE_NUM];
   int          m_syms [RATE_NUM];

   int  n_cmp = 0;
   int  n_bad = 0;
   bit  mon_en = 1'b0;
   bit  aborted = 1'b0;
   int  seen_loads = 0;
   int  done_seen = 0;

   task automatic check(string nm, longint unsigned act, longint unsigned exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(string tag);
      check({tag, "_div_value"}, bus.div_value, 0);
      check({tag, "_gen_en"},    bus.gen_en, 0);
      check({tag, "_seed_load"}, bus.seed_load, 0);
      check({tag, "_rate_idx"},  bus.rate_idx, 0);
      check({tag, "_busy"},      bus.busy, 0);
      check({tag, "_done"},      bus.done, 0);
      check({tag, "_cfg_err"},   bus.cfg_err, 0);
   endtask

   task automatic wr(int addr, int unsigned dv, int sy, bit exp_err);
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = 2'(addr);
      bus.cfg_div  = dv;
      bus.cfg_syms = 16'(sy);
      cyc();
      bus.cfg_we = 1'b0;
      check("cfg_err_write", bus.cfg_err, exp_err);
      if (!exp_err) begin
         m_div[addr]  = dv;
         m_syms[addr] = sy;
      end
   endtask

   task automatic push_done();
      exp_t e;
      e.is_done = 1'b1; e.div = 0; e.idx = 0; e.syms = 0;
      exp_q.push_back(e);
   endtask

   // Expected sweep from the table: the non-zero entries in index order,
   // once (single) or cycled n_loop times (loop), followed by the done.
   task automatic build_expect(bit lp, int n_loop);
      int   v[$];
      exp_t e;
      for (int i = 0; i < RATE_NUM; i++)
         if (m_syms[i] != 0) v.push_back(i);
      if (v.size() > 0) begin
         int n = lp ? n_loop : v.size();
         for (int k = 0; k < n; k++) begin
            e.is_done = 1'b0;
            e.idx     = v[k % v.size()];
            e.div     = m_div[e.idx];
            e.syms    = m_syms[e.idx];
            exp_q.push_back(e);
         end
      end
      push_done();
   endtask

   task automatic run_sweep(bit lp, int n_stop_after, bit busy_write, bit chk_lat);
      int base_loads;
      int base_done;
      bit finished;
      build_expect(lp, n_stop_after);
      aborted    = 1'b0;
      base_loads = seen_loads;
      base_done  = done_seen;
      bus.loop_mode = lp;
      bus.start     = 1'b1;
      cyc();
      bus.start     = 1'b0;
      bus.loop_mode = 1'b0;
      check("busy_after_start", bus.busy, 1);
      for (int c = 0; c < 2000 && done_seen == base_done; c++) begin
         if (chk_lat && c == 1) check("lat_gen_en_low", bus.gen_en, 0);
         if (chk_lat && c == 2) check("lat_gen_en_high", bus.gen_en, 1);
         if (busy_write && c == 1) begin
            bus.cfg_we   = 1'b1;
            bus.cfg_addr = 2'($urandom_range(0, RATE_NUM-1));
            bus.cfg_div  = $urandom_range(DIV_MIN, 1000);
            bus.cfg_syms = 16'd1;
            bus.start    = 1'b1;
         end
         if (busy_write && c == 2) begin
            bus.cfg_we = 1'b0;
            bus.start  = 1'b0;
            check("cfg_err_busy", bus.cfg_err, 1);
         end
         bus.sym_tick = (c < 2) ? 1'b1 : 1'($urandom_range(0, 1));
         if (lp && n_stop_after > 0 && (seen_loads - base_loads) >= n_stop_after && bus.gen_en) begin
            bus.sym_tick = 1'b0;
            aborted  = 1'b1;
            bus.stop = 1'b1;
            cyc();
            bus.stop = 1'b0;
            check("stop_gen_en", bus.gen_en, 0);
            check("stop_done",   bus.done, 1);
            check("stop_busy",   bus.busy, 1);
            cyc();
            check("stop_busy_after", bus.busy, 0);
            break;
         end
         cyc();
      end
      bus.sym_tick = 1'b0;
      finished = (done_seen != base_done);
      if (!finished) begin
         n_cmp++; n_bad++;
         $display("FAIL sweep_timeout: got no done expected done within budget");
      end
      cyc(); cyc();
      check("sb_queue_empty", exp_q.size(), 0);
      check("idle_busy", bus.busy, 0);
      exp_q.delete();
      aborted = 1'b0;
   endtask

   // Scoreboard monitor
   initial begin
      exp_t e;
      bit   prev_gen = 1'b0;
      int   tick_cnt = 0;
      int   cur_syms = 0;
      bit   ok;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (bus.seed_load) begin
               seen_loads++;
               ok = (exp_q.size() > 0) && !exp_q[0].is_done;
               check("sb_entry_avail", ok, 1);
               if (ok) begin
                  e = exp_q.pop_front();
                  check("div_value", bus.div_value, e.div);
                  check("rate_idx", bus.rate_idx, e.idx);
                  check("gen_en_at_load", bus.gen_en, 1);
                  cur_syms = e.syms;
               end
               tick_cnt = 0;
            end
            if (bus.gen_en && bus.sym_tick) tick_cnt++;
            if (prev_gen && !bus.gen_en && !aborted) check("gen_en_ticks", tick_cnt, cur_syms);
            if (bus.done) begin
               done_seen++;
               ok = (exp_q.size() > 0) && exp_q[0].is_done;
               check("sb_done_avail", ok, 1);
               if (ok) e = exp_q.pop_front();
            end
         end
         prev_gen = bus.gen_en;
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.start = 0; bus.stop = 0; bus.loop_mode = 0; bus.cfg_we = 0;
      bus.cfg_addr = '0; bus.cfg_div = '0; bus.cfg_syms = '0; bus.sym_tick = 0;
      for (int i = 0; i < RATE_NUM; i++) begin m_div[i] = DIV_MIN; m_syms[i] = 0; end
      rst_n = 1'b0;
      #23;
      check_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      cyc();
      mon_en = 1'b1;

      // all entries disabled: four SCAN cycles then done, single and loop
      for (int lp = 0; lp < 2; lp++) begin
         push_done();
         bus.loop_mode = 1'(lp);
         bus.start = 1'b1;
         cyc();
         bus.start = 1'b0;
         for (int c = 1; c < 4; c++) begin
            cyc();
            check("scan_no_done", bus.done, 0);
            check("scan_no_gen", bus.gen_en, 0);
         end
         cyc();
         check("scan_done_at_4", bus.done, 1);
         cyc();
         check("scan_idle", bus.busy, 0);
         check("scan_queue_empty", exp_q.size(), 0);
         exp_q.delete();
      end

      // directed table
      wr(0, 100, 3, 0);
      wr(1, 200, 2, 0);
      wr(2, 300, 0, 0);
      wr(3, 50, 1, 0);
      run_sweep(1'b0, 0, 1'b0, 1'b1);

      // loop mode: 0,1,3,0,1 then stop during RUN
      run_sweep(1'b1, 5, 1'b0, 1'b0);

      // rejected writes: too-small divider in IDLE, any write while busy
      wr(1, 3, 7, 1);
      run_sweep(1'b0, 0, 1'b1, 1'b0);
      run_sweep(1'b0, 0, 1'b0, 1'b0);

      // start and stop together in IDLE; stop alone in IDLE
      bus.start = 1'b1; bus.stop = 1'b1;
      cyc();
      bus.start = 1'b0; bus.stop = 1'b0;
      check("start_stop_busy", bus.busy, 0);
      bus.stop = 1'b1;
      cyc();
      bus.stop = 1'b0;
      check("stop_idle_done", bus.done, 0);

      // randomized tables
      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < RATE_NUM; i++) begin
            if ($urandom_range(0, 5) == 0) wr(i, $urandom_range(0, DIV_MIN-1), 2, 1);
            else wr(i, $urandom_range(DIV_MIN, 5000), $urandom_range(0, 3), 0);
         end
         run_sweep(1'b0, 0, 1'b0, 1'b0);
      end

      // reset mid-RUN
      wr(0, 77, 5, 0);
      bus.start = 1'b1;
      cyc();
      bus.start = 1'b0;
      for (int c = 0; c < 50 && !bus.gen_en; c++) cyc();
      check("rst_reach_run", bus.gen_en, 1);
      mon_en = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("mid_reset");
      exp_q.delete();
      for (int i = 0; i < RATE_NUM; i++) begin m_div[i] = DIV_MIN; m_syms[i] = 0; end
      @(negedge clk);
      rst_n = 1'b1;
      cyc();
      mon_en = 1'b1;
      run_sweep(1'b0, 0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/prbs_rate_sweep_ctrl.md
Name: prbs_rate_sweep_ctrl

Overview:
Sequencer for the PRBS/Manchester signal generator. Holds a small table of (divider, symbol-count) entries and steps the generator through them. For each entry it drives the divider value, pulses an LFSR seed reload, enables the generator for the programmed number of symbols, then advances. Supports single-pass and looping sweeps, with a stop abort.

Parameters:
RATE_NUM, 4, number of table entries (power of 2, ≥2)
DIV_W, 32, width of divider value (matches generator divider input)
SYMS_W, 16, width of per-entry symbol count
DIV_MIN, 4, smallest legal divider value

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a sweep from entry 0
stop  in  1  one-cycle pulse; aborts the sweep
loop_mode  in  1  0 = single pass, 1 = repeat; sampled on accepted start
cfg_we  in  1  table write strobe
cfg_addr  in  log2(RATE_NUM)  table entry index
cfg_div  in  DIV_W  divider value to write
cfg_syms  in  SYMS_W  symbol count to write; 0 = entry disabled
sym_tick  in  1  one-cycle pulse from generator per emitted symbol
div_value  out  DIV_W  divider value driven to the generator
gen_en  out  1  generator enable
seed_load  out  1  one-cycle pulse; generator reloads LFSR seed
rate_idx  out  log2(RATE_NUM)  index of the active or last entry
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when a sweep ends
cfg_err  out  1  one-cycle pulse when a write is rejected

Behaviour:
- Reset values: all outputs 0. Table div entries reset to DIV_MIN; syms entries reset to 0. FSM resets to IDLE.
- All outputs are registered.
- Table writes:
  - Accepted only in IDLE with cfg_div ≥ DIV_MIN.
  - Otherwise the table is unchanged and cfg_err pulses the next cycle.
- FSM states: IDLE, SCAN, LOAD, RUN, DONE.
- IDLE:
  - start (with stop low) → SCAN; idx = 0, scan_cnt = 0, ran = 0; loop_mode latched.
  - start and stop in the same cycle → stay IDLE.
- SCAN (one entry checked per cycle):
  - syms[idx] ≠ 0 → LOAD.
  - Otherwise idx increments modulo RATE_NUM and scan_cnt increments.
  - scan_cnt reaching RATE_NUM without finding a valid entry → DONE.
  - Wrap from RATE_NUM-1 to 0 in single mode → DONE.
  - Wrap in loop mode with ran = 0 → DONE.
- LOAD (exactly 1 cycle):
  - div_value ← div[idx], rate_idx ← idx, seed_load = 1, symbol counter ← 0, ran ← 1.
  - Next state RUN; gen_en rises on entry to RUN.
- RUN:
  - gen_en = 1; each sym_tick increments the symbol counter.
  - A sym_tick with counter = syms[idx]-1 → SCAN, with idx+1 (modulo) and scan_cnt ← 0.
  - gen_en drops on that same transition.
- Latency: start at cycle N with entry 0 valid → SCAN at N+1, LOAD at N+2, gen_en high from N+3.
- Rate switch gap: last sym_tick to the next gen_en rise is 2 cycles (SCAN + LOAD) when the next entry is valid; add 1 cycle per skipped entry.
- sym_tick outside RUN is ignored.
- stop:
  - In SCAN, LOAD or RUN → DONE next cycle, gen_en forced 0 immediately, seed_load suppressed.
  - stop in IDLE or DONE is ignored.
  - stop has priority over a same-cycle end-of-entry transition.
- DONE (1 cycle): done = 1, gen_en = 0 → IDLE. div_value and rate_idx hold their last values.
- start while busy is ignored.
- syms = 1: RUN lasts until the first sym_tick.
- Symbol counter is SYMS_W bits and never wraps, since the end check precedes overflow.
- Reset asserted mid-sweep: immediate return to reset values; table contents are also reset.

Test Plan:
- Write entries {div 100 syms 3, div 200 syms 2, syms 0, div 50 syms 1}, single mode, start, tick each symbol → seed_load ×3; div_value 100→200→50; rate_idx 0,1,3; done once; gen_en high for exactly 3, 2, 1 ticks.
- Same table, loop_mode = 1 → after entry 3, rate_idx returns to 0 with div_value 100; runs until stop; stop in RUN → gen_en 0 next cycle, done pulse, busy 0 one cycle later.
- All syms = 0, start → SCAN 4 cycles, then done pulse; seed_load and gen_en never assert; loop mode behaves the same.
- Write cfg_div = 3 in IDLE, then any write while busy → cfg_err pulse each time; table unchanged, confirmed by a subsequent sweep.
- start and stop in the same cycle in IDLE → busy stays 0. sym_tick in SCAN/LOAD → not counted; entry still ends after its full syms count.
- Assert rst_n low mid-RUN → all outputs 0 asynchronously; syms table cleared, so a start afterwards yields immediate done after scan.
